// File: rtl/peak_pkg.sv
// rtl/peak_pkg.sv - shared state encoding, widths, entry type and helpers for the top-K peak detector
package peak_pkg;

  localparam int RANK_WIDTH      = 4;
  localparam int COUNT_WIDTH     = 5;
  localparam int MAX_PEAKS       = 16;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_INDEX_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } peak_state_e;

  typedef struct packed {
    logic                       valid;
    logic [DEF_WIDTH-1:0]       mag;
    logic [DEF_INDEX_WIDTH-1:0] index;
  } peak_entry_t;

  function automatic logic [COUNT_WIDTH-1:0] count_valid(input logic [MAX_PEAKS-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_PEAKS; i++) begin
      n = n + COUNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/peak_sorted_insert.sv
// rtl/peak_sorted_insert.sv - single-cycle insertion of one candidate into a descending K-entry list
module peak_sorted_insert
  import peak_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INDEX_WIDTH = 11,
  parameter int NUM_PEAKS   = 4
) (
  input  logic                                  cand_i,
  input  logic [WIDTH-1:0]                      mag_i,
  input  logic [INDEX_WIDTH-1:0]                index_i,
  input  logic [NUM_PEAKS-1:0]                  list_valid_i,
  input  logic [NUM_PEAKS-1:0][WIDTH-1:0]       list_mag_i,
  input  logic [NUM_PEAKS-1:0][INDEX_WIDTH-1:0] list_index_i,
  output logic [NUM_PEAKS-1:0]                  list_valid_o,
  output logic [NUM_PEAKS-1:0][WIDTH-1:0]       list_mag_o,
  output logic [NUM_PEAKS-1:0][INDEX_WIDTH-1:0] list_index_o
);

  logic [NUM_PEAKS-1:0]                  beats;
  logic [NUM_PEAKS-1:0]                  beats_above;
  logic [NUM_PEAKS-1:0]                  shift_valid;
  logic [NUM_PEAKS-1:0][WIDTH-1:0]       shift_mag;
  logic [NUM_PEAKS-1:0][INDEX_WIDTH-1:0] shift_index;

  // Strict > keeps an equal-magnitude incumbent (earlier bin) ranked above the newcomer.
  always_comb begin
    for (int i = 0; i < NUM_PEAKS; i++) begin
      beats[i] = !list_valid_i[i] || (mag_i > list_mag_i[i]);
    end
  end

  assign beats_above = beats << 1;
  assign shift_valid = list_valid_i << 1;
  assign shift_mag   = list_mag_i << WIDTH;
  assign shift_index = list_index_i << INDEX_WIDTH;

  always_comb begin
    list_valid_o = list_valid_i;
    list_mag_o   = list_mag_i;
    list_index_o = list_index_i;
    if (cand_i) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        if (beats[i] && !beats_above[i]) begin
          list_valid_o[i] = 1'b1;
          list_mag_o[i]   = mag_i;
          list_index_o[i] = index_i;
        end else if (beats[i]) begin
          list_valid_o[i] = shift_valid[i];
          list_mag_o[i]   = shift_mag[i];
          list_index_o[i] = shift_index[i];
        end
      end
    end
  end

endmodule

// File: rtl/fft_topk_peak_detector.sv
// rtl/fft_topk_peak_detector.sv - keeps the K largest above-threshold bins of a frame and streams them out sorted
module fft_topk_peak_detector
  import peak_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FFT_SIZE    = 2048,
  parameter int INDEX_WIDTH = 11,
  parameter int NUM_PEAKS   = 4,
  parameter int MIN_BIN     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       mag_in,
  input  logic                   mag_valid,
  output logic                   mag_ready,
  input  logic                   frame_start,
  input  logic [WIDTH-1:0]       threshold,
  output logic [WIDTH-1:0]       peak_mag,
  output logic [INDEX_WIDTH-1:0] peak_index,
  output logic [RANK_WIDTH-1:0]  peak_rank,
  output logic                   peak_valid,
  input  logic                   peak_ready,
  output logic                   peak_last,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] peak_count,
  output logic                   sync_err
);

  localparam logic [INDEX_WIDTH-1:0] LAST_BIN  = INDEX_WIDTH'(FFT_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] FIRST_BIN = INDEX_WIDTH'(MIN_BIN);

  peak_state_e                           state_q, state_d;
  logic [INDEX_WIDTH-1:0]                bin_cnt_q, bin_cnt_d;
  logic [WIDTH-1:0]                      thr_q, thr_d;
  logic [NUM_PEAKS-1:0]                  list_valid_q, list_valid_d;
  logic [NUM_PEAKS-1:0][WIDTH-1:0]       list_mag_q, list_mag_d;
  logic [NUM_PEAKS-1:0][INDEX_WIDTH-1:0] list_index_q, list_index_d;
  logic [RANK_WIDTH-1:0]                 rank_q, rank_d;
  logic [COUNT_WIDTH-1:0]                count_q, count_d;
  logic                                  frame_done_q, frame_done_d;
  logic                                  sync_err_q, sync_err_d;

  logic                                  beat;
  logic                                  restart;
  logic                                  cand;
  logic [INDEX_WIDTH-1:0]                cur_bin;
  logic [WIDTH-1:0]                      cur_thr;
  logic [NUM_PEAKS-1:0]                  base_valid;
  logic [NUM_PEAKS-1:0]                  ins_valid;
  logic [NUM_PEAKS-1:0][WIDTH-1:0]       ins_mag;
  logic [NUM_PEAKS-1:0][INDEX_WIDTH-1:0] ins_index;

  assign mag_ready = (state_q != ST_DRAIN);
  assign beat      = mag_valid && mag_ready;
  assign restart   = beat && frame_start;

  // A frame_start beat is bin 0 of a fresh, empty list under the newly sampled threshold.
  assign cur_bin    = restart ? '0 : bin_cnt_q;
  assign cur_thr    = restart ? threshold : thr_q;
  assign base_valid = restart ? '0 : list_valid_q;
  assign cand       = beat && (restart || (state_q == ST_ACCUM)) &&
                      (cur_bin >= FIRST_BIN) && (mag_in >= cur_thr);

  peak_sorted_insert #(
    .WIDTH       (WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .NUM_PEAKS   (NUM_PEAKS)
  ) u_insert (
    .cand_i       (cand),
    .mag_i        (mag_in),
    .index_i      (cur_bin),
    .list_valid_i (base_valid),
    .list_mag_i   (list_mag_q),
    .list_index_i (list_index_q),
    .list_valid_o (ins_valid),
    .list_mag_o   (ins_mag),
    .list_index_o (ins_index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bin_cnt_q    <= '0;
      thr_q        <= '0;
      list_valid_q <= '0;
      list_mag_q   <= '0;
      list_index_q <= '0;
      rank_q       <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      thr_q        <= thr_d;
      list_valid_q <= list_valid_d;
      list_mag_q   <= list_mag_d;
      list_index_q <= list_index_d;
      rank_q       <= rank_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    thr_d        = thr_q;
    list_valid_d = list_valid_q;
    list_mag_d   = list_mag_q;
    list_index_d = list_index_q;
    rank_d       = rank_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (frame_start) begin
            state_d      = ST_ACCUM;
            thr_d        = threshold;
            bin_cnt_d    = INDEX_WIDTH'(1);
            list_valid_d = ins_valid;
            list_mag_d   = ins_mag;
            list_index_d = ins_index;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          list_valid_d = ins_valid;
          list_mag_d   = ins_mag;
          list_index_d = ins_index;
          if (frame_start) begin
            sync_err_d = 1'b1;
            thr_d      = threshold;
            bin_cnt_d  = INDEX_WIDTH'(1);
          end else if (bin_cnt_q == LAST_BIN) begin
            state_d      = ST_DRAIN;
            frame_done_d = 1'b1;
            count_d      = count_valid(MAX_PEAKS'(ins_valid));
            rank_d       = '0;
            bin_cnt_d    = '0;
          end else begin
            bin_cnt_d = bin_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else if (peak_ready) begin
          if (peak_last) begin
            state_d = ST_IDLE;
            rank_d  = '0;
          end else begin
            rank_d = rank_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign peak_valid = (state_q == ST_DRAIN) && (count_q != '0);
  assign peak_last  = peak_valid && (COUNT_WIDTH'(rank_q) == (count_q - 1'b1));
  assign peak_rank  = peak_valid ? rank_q : '0;
  assign frame_done = frame_done_q;
  assign peak_count = count_q;
  assign sync_err   = sync_err_q;

  always_comb begin
    peak_mag   = '0;
    peak_index = '0;
    if (peak_valid) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        if (rank_q == RANK_WIDTH'(i)) begin
          peak_mag   = list_mag_q[i];
          peak_index = list_index_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_topk_peak_detector.sv
// tb/tb_fft_topk_peak_detector.sv - scoreboard bench for the FFT top-K peak detector
module tb_fft_topk_peak_detector;
  import peak_pkg::*;

  localparam int WIDTH       = 32;
  localparam int FFT_SIZE    = 2048;
  localparam int INDEX_WIDTH = 11;
  localparam int NUM_PEAKS   = 4;
  localparam int MIN_BIN     = 1;

  logic                   clk;
  logic                   reset;
  logic [WIDTH-1:0]       mag_in;
  logic                   mag_valid;
  logic                   mag_ready;
  logic                   frame_start;
  logic [WIDTH-1:0]       threshold;
  logic [WIDTH-1:0]       peak_mag;
  logic [INDEX_WIDTH-1:0] peak_index;
  logic [RANK_WIDTH-1:0]  peak_rank;
  logic                   peak_valid;
  logic                   peak_ready;
  logic                   peak_last;
  logic                   frame_done;
  logic [COUNT_WIDTH-1:0] peak_count;
  logic                   sync_err;

  int n_cmp;
  int n_bad;

  logic [WIDTH-1:0] frame_mag [FFT_SIZE];
  peak_entry_t      exp_q [$];
  int               cnt_q [$];

  fft_topk_peak_detector #(
    .WIDTH       (WIDTH),
    .FFT_SIZE    (FFT_SIZE),
    .INDEX_WIDTH (INDEX_WIDTH),
    .NUM_PEAKS   (NUM_PEAKS),
    .MIN_BIN     (MIN_BIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mag_in      (mag_in),
    .mag_valid   (mag_valid),
    .mag_ready   (mag_ready),
    .frame_start (frame_start),
    .threshold   (threshold),
    .peak_mag    (peak_mag),
    .peak_index  (peak_index),
    .peak_rank   (peak_rank),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .peak_last   (peak_last),
    .frame_done  (frame_done),
    .peak_count  (peak_count),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: repeated selection of the largest remaining qualifying bin, lowest index on ties.
  task automatic build_expected(input logic [WIDTH-1:0] thr);
    bit          taken [FFT_SIZE];
    int          cnt;
    int          best;
    peak_entry_t e;
    cnt = 0;
    for (int b = 0; b < FFT_SIZE; b++) taken[b] = 1'b0;
    for (int k = 0; k < NUM_PEAKS; k++) begin
      best = -1;
      for (int b = MIN_BIN; b < FFT_SIZE; b++) begin
        if (!taken[b] && frame_mag[b] >= thr && (best < 0 || frame_mag[b] > frame_mag[best]))
          best = b;
      end
      if (best < 0) break;
      taken[best] = 1'b1;
      e.valid = 1'b1;
      e.mag   = frame_mag[best];
      e.index = INDEX_WIDTH'(best);
      exp_q.push_back(e);
      cnt++;
    end
    cnt_q.push_back(cnt);
  endtask

  task automatic drive_frame(input string name, input logic [WIDTH-1:0] thr, input logic expect_sync);
    for (int b = 0; b < FFT_SIZE; b++) begin
      mag_valid   = 1'b1;
      frame_start = (b == 0);
      mag_in      = frame_mag[b];
      threshold   = (b == 0) ? thr : ~thr;
      @(posedge clk); #1;
      if (b == 0) begin
        n_cmp++;
        if (sync_err !== expect_sync) begin
          n_bad++;
          $display("FAIL %s sync_err at frame start: got %b want %b", name, sync_err, expect_sync);
        end
      end
    end
    mag_valid   = 1'b0;
    frame_start = 1'b0;
    build_expected(thr);
  endtask

  task automatic drive_partial(input int n);
    for (int b = 0; b < n; b++) begin
      mag_valid   = 1'b1;
      frame_start = (b == 0);
      mag_in      = 32'hF000_0000 | WIDTH'(b);
      threshold   = '0;
      @(posedge clk); #1;
    end
    mag_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic drain_check(input string name, input int stall_rank, input int stall_cycles);
    int          exp_cnt;
    int          rank;
    int          stalled;
    peak_entry_t e;
    exp_cnt = cnt_q.pop_front();
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s frame_done: got %b want 1", name, frame_done);
    end
    n_cmp++;
    if (peak_count !== COUNT_WIDTH'(exp_cnt)) begin
      n_bad++;
      $display("FAIL %s peak_count: got %0d want %0d", name, peak_count, exp_cnt);
    end
    if (exp_cnt == 0) begin
      n_cmp++;
      if ({peak_valid, mag_ready} !== 2'b00) begin
        n_bad++;
        $display("FAIL %s empty drain valid/ready: got %b%b want 00", name, peak_valid, mag_ready);
      end
      @(posedge clk); #1;
    end
    rank    = 0;
    stalled = 0;
    while (rank < exp_cnt) begin
      e = exp_q[0];
      n_cmp++;
      if ({peak_valid, peak_mag, peak_index, peak_rank, peak_last, mag_ready} !==
          {1'b1, e.mag, e.index, RANK_WIDTH'(rank), (rank == exp_cnt - 1), 1'b0}) begin
        n_bad++;
        $display("FAIL %s entry rank %0d: got v=%b mag=%0d idx=%0d rank=%0d last=%b rdy=%b want v=1 mag=%0d idx=%0d rank=%0d last=%b rdy=0",
                 name, rank, peak_valid, peak_mag, peak_index, peak_rank, peak_last, mag_ready,
                 e.mag, e.index, rank, (rank == exp_cnt - 1));
      end
      if (rank == stall_rank && stalled < stall_cycles) begin
        peak_ready = 1'b0;
        stalled++;
      end else begin
        peak_ready = 1'b1;
        void'(exp_q.pop_front());
        rank++;
      end
      @(posedge clk); #1;
    end
    peak_ready = 1'b0;
    n_cmp++;
    if ({mag_ready, peak_valid, frame_done} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s after drain ready/valid/done: got %b%b%b want 100", name, mag_ready, peak_valid, frame_done);
    end
    n_cmp++;
    if (peak_count !== COUNT_WIDTH'(exp_cnt)) begin
      n_bad++;
      $display("FAIL %s peak_count held: got %0d want %0d", name, peak_count, exp_cnt);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if ({mag_ready, peak_valid, peak_last, frame_done, sync_err} !== 5'b10000) begin
      n_bad++;
      $display("FAIL %s flags rdy/val/last/done/err: got %b%b%b%b%b want 10000",
               name, mag_ready, peak_valid, peak_last, frame_done, sync_err);
    end
    n_cmp++;
    if ({peak_count, peak_mag, peak_index, peak_rank} !== '0) begin
      n_bad++;
      $display("FAIL %s data: got count=%0d mag=%0d idx=%0d rank=%0d want all 0",
               name, peak_count, peak_mag, peak_index, peak_rank);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = WIDTH'(b);
    drive_frame("ramp", '0, 1'b0);
    drain_check("ramp", -1, 0);
  endtask

  task automatic test_single_peak();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = '0;
    frame_mag[0] = 1000;
    frame_mag[7] = 50;
    drive_frame("single", 10, 1'b0);
    drain_check("single", -1, 0);
  endtask

  task automatic test_ties();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = '0;
    frame_mag[5]  = 99;
    frame_mag[9]  = 99;
    frame_mag[12] = 99;
    frame_mag[30] = 99;
    frame_mag[40] = 99;
    drive_frame("ties", 50, 1'b0);
    drain_check("ties", -1, 0);
  endtask

  task automatic test_empty();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = WIDTH'($urandom_range(0, 32'h7FFF_FFFF));
    drive_frame("empty", 32'hFFFF_FFFF, 1'b0);
    drain_check("empty", -1, 0);
  endtask

  task automatic test_stall_restart();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = $urandom;
    drive_frame("stall", 32'h8000_0000, 1'b0);
    drain_check("stall", 1, 5);
    drive_partial(300);
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = WIDTH'($urandom_range(0, 100000));
    drive_frame("restart", 5000, 1'b1);
    drain_check("restart", -1, 0);
  endtask

  task automatic test_reset_midframe();
    drive_partial(1000);
    reset = 1'b1;
    #2;
    check_reset_values("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mag_valid   = 1'b1;
      frame_start = 1'b0;
      mag_in      = 32'h1234_0000 + WIDTH'(i);
      @(posedge clk); #1;
      n_cmp++;
      if ({sync_err, peak_valid, frame_done, mag_ready} !== 4'b1001) begin
        n_bad++;
        $display("FAIL stray beat %0d err/val/done/rdy: got %b%b%b%b want 1001",
                 i, sync_err, peak_valid, frame_done, mag_ready);
      end
    end
    mag_valid = 1'b0;
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = WIDTH'(FFT_SIZE - b);
    drive_frame("post reset", 5, 1'b0);
    drain_check("post reset", -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = WIDTH'($urandom_range(0, 4000));
    frame_mag[100] = 4000;
    frame_mag[200] = 4000;
    drive_frame("b2b a", 3000, 1'b0);
    drain_check("b2b a", -1, 0);
    for (int b = 0; b < FFT_SIZE; b++) frame_mag[b] = $urandom;
    drive_frame("b2b b", 32'hC000_0000, 1'b0);
    drain_check("b2b b", 0, 2);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset       = 1'b1;
    mag_in      = '0;
    mag_valid   = 1'b0;
    frame_start = 1'b0;
    threshold   = '0;
    peak_ready  = 1'b0;
    test_reset();
    test_ramp();
    test_single_peak();
    test_ties();
    test_empty();
    test_stall_restart();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
